// File: rtl/mult_div_unit_pkg.sv
// Core-wide decode constants for the E-stage multiply/divide unit.
// Shared with the controller and hazard unit so MDOp codes and latencies agree.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, computes at launch into staging
// registers, and commits both halves together when the latency counter expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        start,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOUT
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_op_e op;
    assign op = md_op_e'(MDOp);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      hi_st_q, hi_st_d, lo_st_q, lo_st_d;
    logic             wr_q, wr_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] hi_res, lo_res;
    logic        res_vld, is_md, launch;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divide by zero launches normally but marks the result as not to be committed.
    always_comb begin
        hi_res  = 32'd0;
        lo_res  = 32'd0;
        res_vld = 1'b1;
        is_md   = 1'b1;
        case (op)
            MD_MULT:  {hi_res, lo_res} = prod_s;
            MD_MULTU: {hi_res, lo_res} = prod_u;
            MD_DIV: begin
                if (B == 32'd0) begin
                    res_vld = 1'b0;
                end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                    lo_res = 32'h8000_0000;
                    hi_res = 32'd0;
                end else begin
                    lo_res = 32'($signed(A) / $signed(B));
                    hi_res = 32'($signed(A) % $signed(B));
                end
            end
            MD_DIVU: begin
                if (B == 32'd0) begin
                    res_vld = 1'b0;
                end else begin
                    lo_res = A / B;
                    hi_res = A % B;
                end
            end
            default: is_md = 1'b0;
        endcase
    end

    assign busy   = (cnt_q != '0);
    assign launch = start && is_md && !busy && !cancel;

    always_comb begin
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_st_d = hi_st_q;
        lo_st_d = lo_st_q;
        wr_d    = wr_q;
        if (busy) begin
            // Everything else is held off while busy; the hazard unit stalls it.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1) && wr_q) begin
                hi_d = hi_st_q;
                lo_d = lo_st_q;
            end
        end else if (!cancel) begin
            if (launch) begin
                hi_st_d = hi_res;
                lo_st_d = lo_res;
                wr_d    = res_vld;
                cnt_d   = (op == MD_MULT || op == MD_MULTU) ? CNT_W'(MULT_CYCLES)
                                                            : CNT_W'(DIV_CYCLES);
            end
            if (op == MD_MTHI) hi_d = A;
            if (op == MD_MTLO) lo_d = A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_st_q <= 32'd0;
            lo_st_q <= 32'd0;
            wr_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_st_q <= hi_st_d;
            lo_st_q <= lo_st_d;
            wr_q    <= wr_d;
        end
    end

    assign HI    = hi_q;
    assign LO    = lo_q;
    assign MDOUT = (op == MD_MFHI) ? hi_q :
                   (op == MD_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboarded bench for mult_div_unit: expected HI/LO pushed at launch,
// popped and compared when busy falls.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDOp;
    logic        start, cancel;
    logic        busy;
    logic [31:0] HI, LO, MDOUT;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp),
        .start(start), .cancel(cancel), .busy(busy),
        .HI(HI), .LO(LO), .MDOUT(MDOUT)
    );

    always #5 clk = ~clk;

    task automatic drive_launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic canc);
        @(negedge clk);
        MDOp = op; A = a; B = b; start = 1'b1; cancel = canc;
        @(negedge clk);
        MDOp = 4'(MD_NOP); start = 1'b0; cancel = 1'b0;
    endtask

    task automatic count_busy(output int cyc);
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic pop_check(input string name);
        res_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, HI=%h LO=%h", name, HI, LO);
        end else begin
            e = sb.pop_front();
            if (HI !== e.hi || LO !== e.lo) begin
                n_fail++;
                $display("FAIL %s: got HI=%h LO=%h expected HI=%h LO=%h", name, HI, LO, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; A = '0; B = '0; MDOp = '0; start = 1'b0; cancel = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || MDOUT !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b HI=%h LO=%h MDOUT=%h expected all 0", busy, HI, LO, MDOUT);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int cyc;
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF1});
        drive_launch(4'(MD_MULT), 32'hFFFF_FFFD, 32'd5, 1'b0);
        count_busy(cyc);
        n_tests++;
        if (cyc !== 5) begin n_fail++; $display("FAIL mult_busy: got %0d cycles expected 5", cyc); end
        pop_check("mult");
        MDOp = 4'(MD_MFHI); #1;
        n_tests++;
        if (MDOUT !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mfhi: got %h expected ffffffff", MDOUT); end
        MDOp = 4'(MD_MFLO); #1;
        n_tests++;
        if (MDOUT !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mflo: got %h expected fffffff1", MDOUT); end
        MDOp = 4'(MD_NOP); #1;
        n_tests++;
        if (MDOUT !== 32'd0) begin n_fail++; $display("FAIL mdout_nop: got %h expected 0", MDOUT); end
    endtask

    task automatic test_multu();
        int cyc;
        sb.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001});
        drive_launch(4'(MD_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        count_busy(cyc);
        n_tests++;
        if (cyc !== 5) begin n_fail++; $display("FAIL multu_busy: got %0d cycles expected 5", cyc); end
        pop_check("multu");
    endtask

    task automatic test_div();
        int cyc;
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
        drive_launch(4'(MD_DIV), 32'hFFFF_FFF9, 32'd2, 1'b0);
        count_busy(cyc);
        n_tests++;
        if (cyc !== 10) begin n_fail++; $display("FAIL div_busy: got %0d cycles expected 10", cyc); end
        pop_check("div_neg");
        sb.push_back('{hi: 32'd0, lo: 32'h8000_0000});
        drive_launch(4'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        count_busy(cyc);
        pop_check("div_ovf");
        sb.push_back('{hi: 32'd2, lo: 32'd14});
        drive_launch(4'(MD_DIVU), 32'd100, 32'd7, 1'b0);
        count_busy(cyc);
        pop_check("divu");
    endtask

    task automatic test_mt_and_divzero();
        int cyc;
        @(negedge clk);
        MDOp = 4'(MD_MTHI); A = 32'h1234_5678;
        @(negedge clk);
        MDOp = 4'(MD_MFHI); #1;
        n_tests++;
        if (MDOUT !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_fwd: got %h expected 12345678", MDOUT); end
        MDOp = 4'(MD_MTLO); A = 32'h9ABC_DEF0;
        @(negedge clk);
        MDOp = 4'(MD_NOP);
        sb.push_back('{hi: 32'h1234_5678, lo: 32'h9ABC_DEF0});
        pop_check("mthi_mtlo");
        sb.push_back('{hi: 32'h1234_5678, lo: 32'h9ABC_DEF0});
        drive_launch(4'(MD_DIVU), 32'd77, 32'd0, 1'b0);
        count_busy(cyc);
        n_tests++;
        if (cyc !== 10) begin n_fail++; $display("FAIL divzero_busy: got %0d cycles expected 10", cyc); end
        pop_check("divzero");
        @(negedge clk);
        MDOp = 4'(MD_MTHI); A = 32'hDEAD_BEEF; cancel = 1'b1;
        @(negedge clk);
        MDOp = 4'(MD_NOP); cancel = 1'b0;
        n_tests++;
        if (HI !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_cancel: got HI=%h expected 12345678", HI); end
    endtask

    task automatic test_cancel_launch();
        int hits = 0;
        drive_launch(4'(MD_MULT), 32'd3, 32'd4, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (busy) hits++;
            @(negedge clk);
        end
        n_tests++;
        if (hits !== 0 || HI !== 32'h1234_5678 || LO !== 32'h9ABC_DEF0) begin
            n_fail++;
            $display("FAIL cancel_launch: busy_cycles=%0d HI=%h LO=%h expected 0 12345678 9abcdef0", hits, HI, LO);
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
        drive_launch(4'(MD_DIV), 32'hFFFF_FFF9, 32'd2, 1'b0);
        while (busy && cyc < 40) begin
            cyc++;
            if (cyc == 3) begin MDOp = 4'(MD_MULT); A = 32'd3; B = 32'd4; start = 1'b1; end
            if (cyc == 4) begin MDOp = 4'(MD_NOP); start = 1'b0; end
            @(negedge clk);
        end
        n_tests++;
        if (cyc !== 10) begin n_fail++; $display("FAIL busy_start_busy: got %0d cycles expected 10", cyc); end
        pop_check("busy_start_result");
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_relaunch: busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        drive_launch(4'(MD_DIV), 32'd100, 32'd7, 1'b0);
        while (busy && cyc < 4) begin
            cyc++;
            @(negedge clk);
        end
        MDOp = 4'(MD_MFHI);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || MDOUT !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b HI=%h LO=%h MDOUT=%h expected all 0", busy, HI, LO, MDOUT);
        end
        @(negedge clk);
        reset = 1'b0; MDOp = 4'(MD_NOP);
        repeat (12) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_nocommit: busy=%b HI=%h LO=%h expected 0 0 0", busy, HI, LO);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mt_and_divzero();
        test_cancel_launch();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
